uart_cmd_assembler: RTL and testbench

Downstream consumer of the UART receiver. It takes the received byte stream (rx_data/rdy) and assembles two consecutive bytes, high byte first, into a 16-bit command word for the command processor. Each byte is acknowledged back to the receiver via clr_rdy. An inter-byte timeout resynchronises framing. An overrun flag reports a command overwritten before it was consumed.

---
 rtl/uart_cmd_assembler.sv | 165 ++++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// Assembles two consecutive UART bytes (high byte first) into a 16-bit command,
// acknowledging each byte and resynchronising framing on an inter-byte timeout.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CLKS = 52080,
  parameter int unsigned TMO_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        overrun,
  output logic        frame_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  typedef enum logic {
    HIGH = 1'b0,
    LOW  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [7:0]        r_hi_byte;
  logic [15:0]       r_cmd;
  logic              r_cmd_rdy;
  logic              r_overrun;
  logic              r_frame_err;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_skip;

  logic              w_accept;
  logic              w_capture_hi;
  logic              w_complete;
  logic              w_tmo_last;
  logic              w_expire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HIGH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      HIGH: begin
        if (w_accept) begin
          w_next_state = LOW;
        end
      end
      LOW: begin
        if (w_accept || w_tmo_last) begin
          w_next_state = HIGH;
        end
      end
      default: w_next_state = HIGH;
    endcase
  end

  // Output / control decode. r_skip masks the cycle right after an
  // acknowledge, while the receiver's rdy may still be in flight.
  always_comb begin
    w_accept     = rx_rdy && !r_skip;
    w_tmo_last   = (r_tmo_cnt == TMO_LAST);
    w_capture_hi = 1'b0;
    w_complete   = 1'b0;
    w_expire     = 1'b0;
    unique case (r_state)
      HIGH: begin
        w_capture_hi = w_accept;
      end
      LOW: begin
        w_complete = w_accept;
        w_expire   = !w_accept && w_tmo_last;
      end
      default: begin
        w_capture_hi = 1'b0;
      end
    endcase
  end

  assign clr_rx_rdy = w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip <= 1'b0;
    end else begin
      r_skip <= w_accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_byte <= '0;
    end else if (w_capture_hi) begin
      r_hi_byte <= rx_data;
    end else if (w_expire) begin
      r_hi_byte <= '0;
    end
  end

  // Saturating inter-byte counter; only meaningful while awaiting the low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_capture_hi) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == LOW) && !w_accept && (r_tmo_cnt != TMO_MAX)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
    end else if (w_complete) begin
      r_cmd <= {r_hi_byte, rx_data};
    end
  end

  // Completion beats the consumer's clear; a clear also suppresses overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_rdy <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_complete) begin
        r_cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end

      if (clr_cmd_rdy) begin
        r_overrun <= 1'b0;
      end else if (w_complete && r_cmd_rdy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_expire;
    end
  end

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench for uart_cmd_assembler: stimulus pushes expected results,
// an independent monitor pops and compares them as the DUT responds.
module tb_uart_cmd_assembler;

  localparam int unsigned T = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        overrun;
  logic        frame_err;

  typedef struct {
    logic [15:0] cmd;
    logic        rdy;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];
  int   ferr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int bytes_sent = 0;
  int clr_pulses = 0;

  // Reference model of the command stream
  logic        m_hi_valid = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  logic [15:0] m_cmd = 16'h0000;
  logic        m_rdy = 1'b0;
  logic        m_ovr = 1'b0;

  uart_cmd_assembler #(
    .TIMEOUT_CLKS(T),
    .TMO_W(7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_rdy(rx_rdy),
    .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: any acknowledge or consumer clear makes the next cycle's outputs checkable
  logic pending = 1'b0;
  logic prev_clr = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending  = 1'b0;
      prev_clr = 1'b0;
    end else begin
      if (pending) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd", {16'h0, cmd}, {16'h0, mon_e.cmd});
          chk("cmd_rdy", {31'h0, cmd_rdy}, {31'h0, mon_e.rdy});
          chk("overrun", {31'h0, overrun}, {31'h0, mon_e.ovr});
        end
      end
      pending = clr_rx_rdy || clr_cmd_rdy;
      if (clr_rx_rdy) begin
        clr_pulses++;
        chk("clr_rx_rdy_single", {31'h0, prev_clr}, 32'd0);
      end
      prev_clr = clr_rx_rdy;
      if (frame_err) begin
        if (ferr_q.size() == 0) begin
          chk("frame_err_unexpected", 32'd1, 32'd0);
        end else begin
          chk("frame_err_cycle", cyc, ferr_q.pop_front());
        end
      end
    end
  end

  // Present byte b g cycles after the previous acknowledge; optionally clear cmd_rdy with it.
  task automatic send_byte(input logic [7:0] b, input int g, input logic with_clr);
    int   target;
    int   geff;
    int   pres;
    exp_t e;
    logic got;
    target = last_acc + ((g < 2) ? 2 : g);
    geff = ((cyc > target) ? cyc : target) - last_acc;
    if (m_hi_valid && geff > int'(T)) begin
      ferr_q.push_back(last_acc + int'(T) + 1);
      m_hi_valid = 1'b0;
    end
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    if (!m_hi_valid) begin
      m_hi = b;
      m_hi_valid = 1'b1;
      if (with_clr) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end else begin
      m_ovr = with_clr ? 1'b0 : (m_ovr | m_rdy);
      m_cmd = {m_hi, b};
      m_rdy = 1'b1;
      m_hi_valid = 1'b0;
    end
    e.cmd = m_cmd;
    e.rdy = m_rdy;
    e.ovr = m_ovr;
    exp_q.push_back(e);
    pres = cyc;
    rx_data = b;
    rx_rdy = 1'b1;
    clr_cmd_rdy = with_clr;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clr_rx_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      chk("accept_cycle", cyc, pres);
    end
    last_acc = cyc;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    bytes_sent++;
  endtask

  task automatic consume();
    exp_t e;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    e.cmd = m_cmd;
    e.rdy = m_rdy;
    e.ovr = m_ovr;
    exp_q.push_back(e);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_cmd", {16'h0, cmd}, 32'h0);
    chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'd0);
    chk("rst_overrun", {31'h0, overrun}, 32'd0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'd0);
    chk("rst_clr_rx_rdy", {31'h0, clr_rx_rdy}, 32'd0);
    exp_q.delete();
    m_hi_valid = 1'b0;
    m_cmd = 16'h0000;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  initial begin
    int r;
    int g;
    #1;
    do_reset();

    // Basic two-byte command, then consume
    send_byte(8'hA5, 2, 1'b0);
    send_byte(8'h3C, 3, 1'b0);
    chk("clr_pulses_first_cmd", clr_pulses, 2);
    consume();

    // Timeout resynchronisation and its boundary
    send_byte(8'h12, 2, 1'b0);
    send_byte(8'h34, 150, 1'b0);
    send_byte(8'h56, 5, 1'b0);
    send_byte(8'h77, 2, 1'b0);
    send_byte(8'h88, int'(T), 1'b0);
    send_byte(8'h99, 2, 1'b0);
    send_byte(8'hAA, int'(T) + 1, 1'b0);
    send_byte(8'hBB, 4, 1'b0);

    // Overrun and its clear
    consume();
    send_byte(8'h11, 2, 1'b0);
    send_byte(8'h11, 2, 1'b0);
    send_byte(8'h22, 2, 1'b0);
    send_byte(8'h22, 2, 1'b0);
    consume();

    // Low byte coinciding with consumer clear
    send_byte(8'h01, 2, 1'b0);
    send_byte(8'h02, 2, 1'b0);
    send_byte(8'h03, 2, 1'b0);
    send_byte(8'h04, 2, 1'b1);

    // Reset mid-command
    send_byte(8'hC3, 2, 1'b0);
    do_reset();
    send_byte(8'hBE, 2, 1'b0);
    send_byte(8'hEF, 2, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       g = int'($urandom_range(2, 8));
      else if (r == 7) g = int'($urandom_range(T - 1, T + 2));
      else if (r == 8) g = 2 * int'(T);
      else             g = 2;
      send_byte(8'($urandom), g, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 6) == 0) consume();
    end

    if (m_hi_valid) begin
      ferr_q.push_back(last_acc + int'(T) + 1);
      m_hi_valid = 1'b0;
    end
    repeat (2 * T) @(posedge clk);
    @(negedge clk);
    chk("frame_err_missing", ferr_q.size(), 0);
    chk("sb_leftover", exp_q.size(), 0);
    chk("clr_pulse_count", clr_pulses, bytes_sent);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
